hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline scheduler for the 5-stage MIPS core. It sits beside the ID stage and decides, every cycle,
//  whether IF/ID holds (stall), which pipeline registers are flushed and where EX operands come from.
//  It keeps its own shadow of the destination info in the EX, MEM and WB stages.
// PARAMETERS
//  REG_AW   5    register address width
//  CNT_W    16   width of the saturating stall-cycle counter
// PORTS
//  clk            in   1       clock; all state on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  id_valid       in   1       IF/ID holds a real instruction (0 = bubble)
//  id_rs          in   REG_AW  ID source register A
//  id_rt          in   REG_AW  ID source register B
//  id_use_rs      in   1       ID instruction reads rs
//  id_use_rt      in   1       ID instruction reads rt (R-type, beq/bne, sw)
//  id_reg_write   in   1       RegWrite from the control unit
//  id_mem_to_reg  in   1       MemtoReg from the control unit (load)
//  id_wr_reg      in   REG_AW  destination after the RegDst mux
//  ex_branch_taken in  1       branch in EX resolved taken this cycle
//  stall          out  1       hold PC and IF/ID; ID/EX loads a bubble
//  flush_ifid     out  1       zero IF/ID on the next edge
//  flush_idex     out  1       zero ID/EX on the next edge
//  fwd_a          out  2       EX operand A source: 00 regfile, 01 WB, 10 MEM
//  fwd_b          out  2       EX operand B source, same encoding
//  stall_cnt      out  CNT_W   count of stall cycles since reset, saturating
// BEHAVIOUR
//  - Stage record = {valid, wr, ld, reg}. A record is "writing r" iff valid & wr & reg==r & r!=0.
//  - Every edge: WB<=MEM; MEM<=EX; EX<=bubble if (stall|flush_idex|!id_valid), else the ID record
//    (including id_rs/id_rt/use flags, held for EX forwarding).
//  - Load-use hazard (combinational): EX record has ld=1 and is writing a register the ID instruction reads.
//  - stall = hazard & !ex_branch_taken. Branch flush wins over stall; the ID instruction is on the
//    wrong path.
//  - ex_branch_taken=1: flush_ifid=flush_idex=1 in that same cycle, which gives two bubbles. Otherwise both are 0.
//  - fwd_x: 10 if the MEM record is writing the EX source; else 01 if the WB record is; else 00.
//    MEM has priority. Unused sources (use flag 0) give 00.
//  - stall_cnt increments on each cycle with stall=1 and holds at 2^CNT_W-1.
//  - The register file writes before it reads, so the WB stage never causes a stall.
//  - Reset (at any time, asynchronous): all records invalid; stall=0, flushes=0, fwd=00, stall_cnt=0.
//    There is no stall on the first cycle after release.
//  - Latency: stall, flush and fwd are combinational from inputs and registered records,
//    valid in the same cycle.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: behaviour above (load-use costs 1 stall cycle, ALU-ALU costs 0).
//  Not defined: fwd_a=fwd_b=00 constantly. Hazard = the EX or MEM record is writing any register the
//    ID instruction reads, regardless of ld. Dependent back-to-back ALU ops stall 2 cycles;
//    a gap of one stalls 1 cycle.
// STRUCTURE
//  - hazard_pkg holds:
//    - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
//    - typedef stage_rec_t {valid, wr, ld, reg[4:0]};
//    - function writes_reg(rec, r).
//  - One sub-module, hazard_fwd_sel: combinational MEM/WB priority select.
//    It is instantiated twice (A and B); its output is tied to FWD_RF when forwarding is compiled out.
// TESTING
//  1. lw $8,0($0) then add $9,$8,$8: stall=1 for exactly 1 cycle, stall_cnt=1.
//     When the add is in EX: fwd_a=fwd_b=01.
//  2. add $1,$2,$3 then sub $4,$1,$5: stall never asserts; when the sub is in EX, fwd_a=10, fwd_b=00.
//  3. add $1,.. ; or $1,.. ; and $6,$1,$1: MEM wins, fwd_a=fwd_b=10.
//  4. addi $0,$0,5 then add $7,$0,$0: no stall, fwd=00.
//     lw $0 then a reader of $0: no stall.
//  5. Load-use hazard with ex_branch_taken=1 in the same cycle: stall=0, flush_ifid=flush_idex=1.
//     The next two EX records are bubbles.
//  6. HAZARD_FORWARDING_EN undefined:
//     - add $1 then a reader of $1: 2 stall cycles;
//     - assert rst_n=0 mid-stall: stall drops immediately and stall_cnt=0.
//     Separately, force 2^16 stall cycles: stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller.
//   FWD_*        operand-source encodings driven on fwd_a / fwd_b
//   stage_rec_t  destination shadow kept per stage {valid, wr, ld, dst}
//   src_rec_t    source fields of the instruction held in EX (forwarding only)
//   writes_reg   true when a record will write a given non-zero register
//   reads_rec    true when an instruction's used sources hit a record's destination
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             ld;
        logic [REG_W-1:0] dst;
    } stage_rec_t;

    typedef struct packed {
        logic             use_rs;
        logic             use_rt;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } src_rec_t;

    localparam stage_rec_t BUBBLE     = '0;
    localparam src_rec_t   SRC_BUBBLE = '0;

    // $0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic writes_reg(input stage_rec_t rec, input logic [REG_W-1:0] r);
        return rec.valid && rec.wr && (rec.dst == r) && (r != '0);
    endfunction

    function automatic logic reads_rec(input stage_rec_t       rec,
                                       input logic             use_rs,
                                       input logic [REG_W-1:0] rs,
                                       input logic             use_rt,
                                       input logic [REG_W-1:0] rt);
        return (use_rs && writes_reg(rec, rs)) || (use_rt && writes_reg(rec, rt));
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: operand source select for one EX operand.
//   mem_rec / wb_rec  destination shadows of the MEM and WB stages
//   use_src / src     whether the EX instruction reads this operand, and its register
//   sel               FWD_MEM if MEM writes src, else FWD_WB if WB does, else FWD_RF
// MEM holds the younger result, so it wins over WB.
import hazard_pkg::*;

module hazard_fwd_sel (
    input  stage_rec_t       mem_rec,
    input  stage_rec_t       wb_rec,
    input  logic             use_src,
    input  logic [REG_W-1:0] src,
    output logic [1:0]       sel
);

    // The load flag does not matter once a result exists in MEM or WB.
    logic unused_ld;
    assign unused_ld = mem_rec.ld ^ wb_rec.ld;

    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (writes_reg(mem_rec, src)) begin
                sel = FWD_MEM;
            end else if (writes_reg(wb_rec, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / forwarding scheduler for the 5-stage MIPS pipeline.
// Sits beside ID and keeps its own shadow of the EX, MEM (and WB) destinations.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid                        IF/ID holds a real instruction
//   id_rs, id_rt, id_use_rs/rt      ID sources and whether they are read
//   id_reg_write, id_mem_to_reg     control bits of the ID instruction
//   id_wr_reg                       ID destination after the RegDst mux
//   ex_branch_taken                 branch in EX resolved taken this cycle
//   stall                           hold PC and IF/ID, bubble into ID/EX
//   flush_ifid, flush_idex          zero those pipeline registers next edge
//   fwd_a, fwd_b                    EX operand sources (FWD_RF / FWD_WB / FWD_MEM)
//   stall_cnt                       saturating count of stall cycles since reset
// Build option HAZARD_FORWARDING_EN:
//   defined   - MEM/WB forwarding; only a load feeding the next instruction stalls.
//   undefined - no forwarding (fwd = 00); any EX or MEM producer of an ID source stalls.
// stall, flushes and fwd are combinational in the same cycle.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_rec_t id_rec;
    stage_rec_t ex_rec;
    stage_rec_t mem_rec;
    logic       hazard;
    logic       ex_load_bubble;

    assign id_rec = '{valid: id_valid, wr: id_reg_write, ld: id_mem_to_reg, dst: id_wr_reg};

    // A branch in EX puts the ID instruction on the wrong path, so the flush
    // overrides any stall. Flushes are held low while reset is asserted.
    assign flush_ifid = ex_branch_taken && rst_n;
    assign flush_idex = ex_branch_taken && rst_n;
    assign stall      = hazard && !ex_branch_taken;

    assign ex_load_bubble = stall || flush_idex || !id_valid;

`ifdef HAZARD_FORWARDING_EN
    stage_rec_t wb_rec;
    src_rec_t   ex_src;

    // With forwarding only a load still in EX is too late for the ID reader.
    assign hazard = id_valid && ex_rec.ld &&
                    reads_rec(ex_rec, id_use_rs, id_rs, id_use_rt, id_rt);

    hazard_fwd_sel u_fwd_a (
        .mem_rec (mem_rec),
        .wb_rec  (wb_rec),
        .use_src (ex_src.use_rs),
        .src     (ex_src.rs),
        .sel     (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .mem_rec (mem_rec),
        .wb_rec  (wb_rec),
        .use_src (ex_src.use_rt),
        .src     (ex_src.rt),
        .sel     (fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rec <= BUBBLE;
            ex_src <= SRC_BUBBLE;
        end else begin
            wb_rec <= mem_rec;
            if (ex_load_bubble) begin
                ex_src <= SRC_BUBBLE;
            end else begin
                ex_src <= '{use_rs: id_use_rs, use_rt: id_use_rt, rs: id_rs, rt: id_rt};
            end
        end
    end
`else
    // Without forwarding the reader waits until the producer reaches WB; the
    // register file writes before it reads, so WB needs no shadow here.
    assign hazard = id_valid &&
                    (reads_rec(ex_rec,  id_use_rs, id_rs, id_use_rt, id_rt) ||
                     reads_rec(mem_rec, id_use_rs, id_rs, id_use_rt, id_rt));
    assign fwd_a  = FWD_RF;
    assign fwd_b  = FWD_RF;

    logic unused_ld;
    assign unused_ld = mem_rec.ld;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rec    <= BUBBLE;
            mem_rec   <= BUBBLE;
            stall_cnt <= '0;
        end else begin
            mem_rec <= ex_rec;
            if (ex_load_bubble) begin
                ex_rec <= BUBBLE;
            end else begin
                ex_rec <= id_rec;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_reg_write;
    logic        id_mem_to_reg;
    logic [4:0]  id_wr_reg;
    logic        ex_branch_taken;

    logic        stall, flush_ifid, flush_idex;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    // Narrow-counter copy driven by the same stimulus, used for saturation.
    logic        sat_stall, sat_flush_ifid, sat_flush_idex;
    logic [1:0]  sat_fwd_a, sat_fwd_b;
    logic [2:0]  sat_cnt;

    logic [6:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_reg_write    (id_reg_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_wr_reg       (id_wr_reg),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt)
    );

    hazard_ctrl #(.REG_AW(5), .CNT_W(3)) dut_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_reg_write    (id_reg_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_wr_reg       (id_wr_reg),
        .ex_branch_taken (ex_branch_taken),
        .stall           (sat_stall),
        .flush_ifid      (sat_flush_ifid),
        .flush_idex      (sat_flush_idex),
        .fwd_a           (sat_fwd_a),
        .fwd_b           (sat_fwd_b),
        .stall_cnt       (sat_cnt)
    );

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic rw,
                          input logic m2r, input logic [4:0] wr);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_use_rs     = urs;
        id_use_rt     = urt;
        id_reg_write  = rw;
        id_mem_to_reg = m2r;
        id_wr_reg     = wr;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic lw(input logic [4:0] dst, input logic [4:0] base);
        set_id(1'b1, base, dst, 1'b1, 1'b0, 1'b1, 1'b1, dst);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, rd);
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_out(input logic s, input logic f, input logic [1:0] fa, input logic [1:0] fb);
        exp_q.push_back({s, f, f, fa, fb});
        if (s) exp_cnt++;
    endtask

    task automatic check_out(input string tag);
        logic [6:0] e;
        logic [6:0] o;
        logic [6:0] os;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed=%b", tag,
                   {stall, flush_ifid, flush_idex, fwd_a, fwd_b});
        end else begin
            e  = exp_q.pop_front();
            o  = {stall, flush_ifid, flush_idex, fwd_a, fwd_b};
            os = {sat_stall, sat_flush_ifid, sat_flush_idex, sat_fwd_a, sat_fwd_b};
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: {stall,fl_ifid,fl_idex,fwd_a,fwd_b} observed=%b expected=%b", tag, o, e);
            end
            checks++;
            assert (os === e) else begin
                errors++;
                $error("FAIL %s_sat: outputs observed=%b expected=%b", tag, os, e);
            end
        end
    endtask

    task automatic check_cnt(input string tag);
        logic [15:0] e16;
        logic [2:0]  e3;
        e16 = exp_cnt[15:0];
        e3  = (exp_cnt > 7) ? 3'd7 : exp_cnt[2:0];
        checks++;
        assert (stall_cnt === e16) else begin
            errors++;
            $error("FAIL %s: stall_cnt observed=%0d expected=%0d", tag, stall_cnt, e16);
        end
        checks++;
        assert (sat_cnt === e3) else begin
            errors++;
            $error("FAIL %s_sat: stall_cnt observed=%0d expected=%0d", tag, sat_cnt, e3);
        end
    endtask

    // Inputs are driven just after a falling edge; outputs sampled 2 ns later.
    task automatic step(input string tag);
        #2;
        check_out(tag);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3; i++) begin
            nop();
            expect_out(1'b0, 1'b0, 2'b00, 2'b00);
            step(tag);
        end
    endtask

    // lw $8,0($0) ; add $9,$8,$8 followed by enough bubbles to empty the pipe.
    task automatic load_use(input string tag);
        lw(5'd8, 5'd0);           expect_out(1'b0, 1'b0, 2'b00, 2'b00); step({tag, "_lw"});
        alu(5'd9, 5'd8, 5'd8);    expect_out(1'b1, 1'b0, 2'b00, 2'b00); step({tag, "_stall1"});
`ifdef HAZARD_FORWARDING_EN
        alu(5'd9, 5'd8, 5'd8);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step({tag, "_release"});
        nop();                    expect_out(1'b0, 1'b0, 2'b01, 2'b01); step({tag, "_fwd_wb"});
`else
        alu(5'd9, 5'd8, 5'd8);    expect_out(1'b1, 1'b0, 2'b00, 2'b00); step({tag, "_stall2"});
        alu(5'd9, 5'd8, 5'd8);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step({tag, "_release"});
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step({tag, "_in_ex"});
`endif
        drain({tag, "_drain"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a taken branch on the input: everything must stay quiet.
        nop();
        ex_branch_taken = 1'b1;
        expect_out(1'b0, 1'b0, 2'b00, 2'b00);
        #2;
        check_out("reset_outputs");
        check_cnt("reset_cnt");
        ex_branch_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First cycle after release: no stall.
        expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("first_cycle");

        // 1. load-use
        load_use("t1");
        check_cnt("t1_cnt");

        // 2. add $1,$2,$3 ; sub $4,$1,$5
        alu(5'd1, 5'd2, 5'd3);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t2_add");
`ifdef HAZARD_FORWARDING_EN
        alu(5'd4, 5'd1, 5'd5);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t2_sub");
        nop();                    expect_out(1'b0, 1'b0, 2'b10, 2'b00); step("t2_fwd_mem");
`else
        alu(5'd4, 5'd1, 5'd5);    expect_out(1'b1, 1'b0, 2'b00, 2'b00); step("t2_stall1");
        alu(5'd4, 5'd1, 5'd5);    expect_out(1'b1, 1'b0, 2'b00, 2'b00); step("t2_stall2");
        alu(5'd4, 5'd1, 5'd5);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t2_release");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t2_in_ex");
`endif
        drain("t2_drain");

        // 2b. one-instruction gap between producer and reader
        alu(5'd1, 5'd2, 5'd3);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("gap_add");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("gap_nop");
`ifdef HAZARD_FORWARDING_EN
        alu(5'd4, 5'd1, 5'd5);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("gap_sub");
        nop();                    expect_out(1'b0, 1'b0, 2'b01, 2'b00); step("gap_fwd_wb");
`else
        alu(5'd4, 5'd1, 5'd5);    expect_out(1'b1, 1'b0, 2'b00, 2'b00); step("gap_stall");
        alu(5'd4, 5'd1, 5'd5);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("gap_release");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("gap_in_ex");
`endif
        drain("gap_drain");
        check_cnt("gap_cnt");

        // 3. add $1 ; or $1 ; and $6,$1,$1
        alu(5'd1, 5'd2, 5'd3);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t3_add");
        alu(5'd1, 5'd4, 5'd5);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t3_or");
`ifdef HAZARD_FORWARDING_EN
        alu(5'd6, 5'd1, 5'd1);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t3_and");
        nop();                    expect_out(1'b0, 1'b0, 2'b10, 2'b10); step("t3_mem_wins");
`else
        alu(5'd6, 5'd1, 5'd1);    expect_out(1'b1, 1'b0, 2'b00, 2'b00); step("t3_stall1");
        alu(5'd6, 5'd1, 5'd1);    expect_out(1'b1, 1'b0, 2'b00, 2'b00); step("t3_stall2");
        alu(5'd6, 5'd1, 5'd1);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t3_release");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t3_in_ex");
`endif
        drain("t3_drain");

        // Unused source: rt field names $1 but is not read.
        alu(5'd1, 5'd2, 5'd3);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("use_add");
        set_id(1'b1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);
        expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("use_no_stall");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("use_no_fwd");
        drain("use_drain");

        // 4. writes to $0 never create a dependency
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t4_addi0");
        alu(5'd7, 5'd0, 5'd0);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t4_add_r0");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t4_no_fwd");
        lw(5'd0, 5'd0);           expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t4_lw0");
        alu(5'd7, 5'd0, 5'd0);    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t4_lw0_reader");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t4_lw0_no_fwd");
        drain("t4_drain");
        check_cnt("t4_cnt");

        // 5. load-use coinciding with a taken branch: flush wins, no stall.
        lw(5'd8, 5'd0);           expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t5_lw");
        alu(5'd9, 5'd8, 5'd8);
        ex_branch_taken = 1'b1;   expect_out(1'b0, 1'b1, 2'b00, 2'b00); step("t5_flush");
        ex_branch_taken = 1'b0;
        // A reader of $9 would stall (no-forwarding build) if the flushed add had reached EX.
        alu(5'd10, 5'd9, 5'd0);   expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t5_ex_bubble1");
        // With forwarding, the flushed add in MEM would show up as fwd_a=10.
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t5_ex_bubble2");
        drain("t5_drain");
        check_cnt("t5_cnt");

        // 6. asynchronous reset in the middle of a stall
        lw(5'd8, 5'd0);           expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t6_lw");
        alu(5'd9, 5'd8, 5'd8);    expect_out(1'b1, 1'b0, 2'b00, 2'b00);
        #2;
        check_out("t6_stall");
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        expect_out(1'b0, 1'b0, 2'b00, 2'b00);
        check_out("t6_rst_outputs");
        check_cnt("t6_rst_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        // Same ID instruction after release: the shadows are empty, so no stall.
        expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t6_after_release");
        nop();                    expect_out(1'b0, 1'b0, 2'b00, 2'b00); step("t6_in_ex");
        drain("t6_drain");
        check_cnt("t6_cnt_after");

        // Saturation: repeated load-use pairs push the 3-bit copy past 7.
        for (int i = 0; i < 8; i++) begin
            load_use("sat");
            if (i == 1) check_cnt("sat_partial");
        end
        check_cnt("sat_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
